// File: rtl/store_port_responder.sv
// Store-port responder: grants byte-enabled writes into a small FIFO and drains them
// one at a time to a single-port backing memory over a req/gnt/ack handshake.
module store_port_responder #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned TAG_WIDTH   = 44,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [INDEX_WIDTH-1:0]           address_index_i,
  input  logic [TAG_WIDTH-1:0]             address_tag_i,
  input  logic [XLEN-1:0]                  data_wdata_i,
  input  logic [XLEN/8-1:0]                data_be_i,
  input  logic [1:0]                       data_size_i,
  input  logic                             data_we_i,
  input  logic                             data_req_i,
  input  logic                             kill_req_i,
  output logic                             data_gnt_o,
  output logic                             data_rvalid_o,
  output logic                             err_o,
  output logic                             mem_req_o,
  output logic [TAG_WIDTH+INDEX_WIDTH-1:0] mem_addr_o,
  output logic [XLEN-1:0]                  mem_wdata_o,
  output logic [XLEN/8-1:0]                mem_be_o,
  input  logic                             mem_gnt_i,
  input  logic                             mem_ack_i,
  output logic                             empty_o,
  output logic [$clog2(DEPTH):0]           count_o
);

  localparam int unsigned AW = TAG_WIDTH + INDEX_WIDTH;
  localparam int unsigned BW = XLEN / 8;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWaitAck} state_e;

  state_e          r_state, w_state_next;
  logic [AW-1:0]   r_addr  [DEPTH];
  logic [XLEN-1:0] r_wdata [DEPTH];
  logic [BW-1:0]   r_be    [DEPTH];
  logic [1:0]      r_size  [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count, w_count_next;
  logic            r_rvalid;

  logic            w_push, w_pop, w_mem_req;
  logic            w_unused;

  // Grant looks only at the registered count; a same-cycle pop never frees a slot.
  assign w_push     = data_req_i & data_we_i & (r_count != FullCount);
  assign data_gnt_o = w_push;
  assign err_o      = data_req_i & ~data_we_i;

  // Kill is ignored and size is carried but not used by the backing memory.
  assign w_unused = ^{kill_req_i, r_size[r_rd_ptr]};

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_mem_req    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) w_state_next = StReq;
      end
      StReq: begin
        w_mem_req = 1'b1;
        if (mem_gnt_i) begin
          if (mem_ack_i) begin
            w_pop        = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_state_next = StWaitAck;
          end
        end
      end
      StWaitAck: begin
        if (mem_ack_i) begin
          w_pop        = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= StIdle;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_rvalid <= w_push;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
        r_be[i]    <= '0;
        r_size[i]  <= '0;
      end
    end else if (w_push) begin
      r_addr[r_wr_ptr]  <= {address_tag_i, address_index_i};
      r_wdata[r_wr_ptr] <= data_wdata_i;
      r_be[r_wr_ptr]    <= data_be_i;
      r_size[r_wr_ptr]  <= data_size_i;
    end
  end

  assign data_rvalid_o = r_rvalid;
  assign mem_req_o     = w_mem_req;
  assign mem_addr_o    = w_mem_req ? r_addr[r_rd_ptr]  : '0;
  assign mem_wdata_o   = w_mem_req ? r_wdata[r_rd_ptr] : '0;
  assign mem_be_o      = w_mem_req ? r_be[r_rd_ptr]    : '0;
  assign empty_o       = (r_count == '0) & (r_state == StIdle);
  assign count_o       = r_count;

endmodule

// File: tb/tb_store_port_responder.sv
// Directed bench for store_port_responder: grant/response timing, FIFO full, drain order,
// read rejection, kill, and asynchronous reset mid-transfer.
module tb_store_port_responder;

  localparam int unsigned XLEN = 64;
  localparam int unsigned IW   = 12;
  localparam int unsigned TW   = 44;
  localparam int unsigned D    = 4;
  localparam int unsigned AW   = TW + IW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IW-1:0]   idx = '0;
  logic [TW-1:0]   tag = '0;
  logic [XLEN-1:0] wdata = '0;
  logic [7:0]      be = '0;
  logic [1:0]      size = '0;
  logic            we = 1'b0;
  logic            req = 1'b0;
  logic            kill = 1'b0;
  logic            data_gnt_o, data_rvalid_o, err_o, mem_req_o, empty_o;
  logic [AW-1:0]   mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [7:0]      mem_be_o;
  logic [2:0]      count_o;
  logic            mem_gnt = 1'b0;
  logic            mem_ack = 1'b0;

  // 0: gnt/ack tied high, 1: manual, 2: random stall, 3: gnt without ack
  int              mem_mode = 0;
  logic            man_gnt = 1'b0;
  logic            man_ack = 1'b0;
  int              stall = 0;

  logic [127:0]    exp_q[$];
  logic [127:0]    cap_q[$];
  int              n_vec = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  store_port_responder #(
    .XLEN(XLEN), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .DEPTH(D)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .address_index_i(idx), .address_tag_i(tag), .data_wdata_i(wdata),
    .data_be_i(be), .data_size_i(size), .data_we_i(we), .data_req_i(req),
    .kill_req_i(kill), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .err_o(err_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt),
    .mem_ack_i(mem_ack), .empty_o(empty_o), .count_o(count_o)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Backing-memory model and write monitor.
  always begin
    @(negedge clk);
    #1;
    case (mem_mode)
      0: begin mem_gnt = 1'b1; mem_ack = 1'b1; end
      1: begin mem_gnt = man_gnt; mem_ack = man_ack; end
      2: begin
        if (mem_req_o && stall == 0) begin
          mem_gnt = 1'b1; mem_ack = 1'b1; stall = $urandom_range(0, 3);
        end else begin
          mem_gnt = 1'b0; mem_ack = 1'b0;
          if (mem_req_o) stall--;
        end
      end
      default: begin mem_gnt = mem_req_o; mem_ack = 1'b0; end
    endcase
    #1;
    if (mem_req_o && mem_gnt) cap_q.push_back({mem_addr_o, mem_wdata_o, mem_be_o});
  end

  task automatic drive_wr(input logic [IW-1:0] i_idx, input logic [TW-1:0] i_tag,
                          input logic [XLEN-1:0] i_data, input logic [7:0] i_be);
    idx = i_idx; tag = i_tag; wdata = i_data; be = i_be; size = 2'd3;
    we = 1'b1; req = 1'b1;
  endtask

  task automatic idle_in();
    req = 1'b0; we = 1'b0; kill = 1'b0;
  endtask

  task automatic expect_wr();
    exp_q.push_back({tag, idx, wdata, be});
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #3;
      if (empty_o) break;
    end
    check("drain_done", empty_o, 1);
  endtask

  task automatic sb_compare();
    check("sb_count", cap_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < cap_q.size()) check("sb_entry", cap_q[k], exp_q[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waited;
    int cap_n;

    // 1: reset and a single write with memory always ready
    #3;
    check("rst_empty", empty_o, 1);
    check("rst_count", count_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_rvalid", data_rvalid_o, 0);
    check("rst_err", err_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_wr(12'h010, 44'h1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    #3;
    check("t1_gnt", data_gnt_o, 1);
    check("t1_rvalid_early", data_rvalid_o, 0);
    expect_wr();
    @(negedge clk);
    idle_in();
    #3;
    check("t1_rvalid", data_rvalid_o, 1);
    check("t1_count", count_o, 1);
    check("t1_not_empty", empty_o, 0);
    check("t1_no_req_yet", mem_req_o, 0);
    check("t1_addr_zero", mem_addr_o, 0);
    @(negedge clk);
    #3;
    check("t1_mem_req", mem_req_o, 1);
    check("t1_mem_addr", mem_addr_o, 56'h1010);
    check("t1_mem_wdata", mem_wdata_o, 64'hDEAD_BEEF_CAFE_F00D);
    check("t1_mem_be", mem_be_o, 8'hFF);
    check("t1_rvalid_once", data_rvalid_o, 0);
    @(negedge clk);
    #3;
    check("t1_empty_again", empty_o, 1);
    check("t1_req_drop", mem_req_o, 0);

    // 2: fill the FIFO with memory stalled
    mem_mode = 1; man_gnt = 1'b0; man_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_wr(12'h100 + 12'(i), 44'h20 + 44'(i), 64'h1111_0000_2222_0000 + 64'(i), 8'hFF);
      #3;
      check("t2_gnt", data_gnt_o, 1);
      expect_wr();
    end
    @(negedge clk);
    drive_wr(12'h104, 44'h24, 64'h1111_0000_2222_0004, 8'hFF);
    #3;
    check("t2_count_full", count_o, 4);
    check("t2_full_gnt", data_gnt_o, 0);
    @(negedge clk);
    #3;
    check("t2_full_gnt2", data_gnt_o, 0);
    check("t2_req_held", mem_req_o, 1);
    check("t2_head_addr", mem_addr_o, {44'h20, 12'h100});
    @(negedge clk);
    man_gnt = 1'b1; man_ack = 1'b1;
    #3;
    check("t2_pop_cycle_gnt", data_gnt_o, 0);
    @(negedge clk);
    man_gnt = 1'b0; man_ack = 1'b0;
    #3;
    check("t2_after_pop_gnt", data_gnt_o, 1);
    check("t2_after_pop_count", count_o, 3);
    check("t2_idle_after_pop", mem_req_o, 0);
    expect_wr();
    @(negedge clk);
    idle_in();
    #3;
    check("t2_refill_count", count_o, 4);
    mem_mode = 0;
    wait_empty();

    // 3: wrap-around with random memory stalls
    mem_mode = 2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_wr(12'h200 + 12'(3 * i), 44'h3000 + 44'(i),
               64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h1111_1111_1111_1111),
               i[0] ? 8'hF0 : 8'h0F);
      #3;
      waited = 0;
      while (!data_gnt_o && waited < 20) begin
        @(negedge clk);
        #3;
        waited++;
      end
      check("t3_gnt", data_gnt_o, 1);
      expect_wr();
    end
    @(negedge clk);
    idle_in();
    wait_empty();
    mem_mode = 0;
    sb_compare();

    // 4: read request is rejected
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idx = 12'h3FF; tag = 44'h5; req = 1'b1; we = 1'b0;
      #3;
      check("t4_gnt", data_gnt_o, 0);
      check("t4_err", err_o, 1);
      check("t4_count", count_o, 0);
    end
    @(negedge clk);
    idle_in();
    #3;
    check("t4_err_drop", err_o, 0);
    check("t4_no_rvalid", data_rvalid_o, 0);
    check("t4_empty", empty_o, 1);

    // 5: kill after grant has no effect
    @(negedge clk);
    drive_wr(12'hABC, 44'h0000_0000_0777, 64'h5A5A_A5A5_0F0F_F0F0, 8'h3C);
    #3;
    check("t5_gnt", data_gnt_o, 1);
    expect_wr();
    @(negedge clk);
    idle_in();
    kill = 1'b1;
    #3;
    check("t5_rvalid", data_rvalid_o, 1);
    @(negedge clk);
    kill = 1'b0;
    wait_empty();
    sb_compare();

    // 6: reset while waiting for an ack with three entries queued
    mem_mode = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_wr(12'h400 + 12'(i), 44'h60 + 44'(i), 64'hCC00 + 64'(i), 8'hFF);
      #3;
      check("t6_gnt", data_gnt_o, 1);
    end
    @(negedge clk);
    idle_in();
    #3;
    check("t6_wait_ack_req", mem_req_o, 0);
    check("t6_count3", count_o, 3);
    check("t6_not_empty", empty_o, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", mem_req_o, 0);
    check("t6_rst_count", count_o, 0);
    check("t6_rst_empty", empty_o, 1);
    cap_n = cap_q.size();
    mem_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      check("t6_post_req", mem_req_o, 0);
      check("t6_post_count", count_o, 0);
      check("t6_post_empty", empty_o, 1);
    end
    check("t6_no_new_writes", cap_q.size(), cap_n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_port_responder.md
Name: store_port_responder

Overview:
- Memory-side responder for the data-cache store request port driven by the store buffer.
- Grants byte-enabled write requests and queues them in a DEPTH-entry write FIFO.
- Drains the FIFO one entry at a time to a single-port backing memory using a req/gnt/ack handshake.
- Serves as the cache-side endpoint for store traffic in stand-alone subsystem benches and in the write-through path.

Parameters:
XLEN, 64, data width in bits; data_be width is XLEN/8
INDEX_WIDTH, 12, address index bits
TAG_WIDTH, 44, address tag bits; the physical address is {tag, index}, TAG_WIDTH+INDEX_WIDTH bits
DEPTH, 4, write FIFO entries; power of two, at least 2

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
address_index_i  in  INDEX_WIDTH  request index
address_tag_i  in  TAG_WIDTH  request tag, valid in the same cycle as data_req_i
data_wdata_i  in  XLEN  write data, already lane-aligned
data_be_i  in  XLEN/8  byte enables
data_size_i  in  2  log2 of the transfer size in bytes
data_we_i  in  1  write request; 0 means read
data_req_i  in  1  request valid
kill_req_i  in  1  kill request
data_gnt_o  out  1  request granted
data_rvalid_o  out  1  write response
err_o  out  1  unsupported-request pulse
mem_req_o  out  1  backing-memory request
mem_addr_o  out  TAG_WIDTH+INDEX_WIDTH  backing-memory address
mem_wdata_o  out  XLEN  backing-memory write data
mem_be_o  out  XLEN/8  backing-memory byte enables
mem_gnt_i  in  1  backing memory accepted the request
mem_ack_i  in  1  backing-memory write complete
empty_o  out  1  FIFO empty and drain FSM idle
count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0 except empty_o=1. FIFO pointers and count are 0; the FSM is in IDLE. Reset mid-transfer drops all queued entries and any outstanding memory request.
- Grant: data_gnt_o = data_req_i & data_we_i & (count_q != DEPTH).
  - The decision uses the registered count only. A pop in the same cycle does not free a slot for a push.
  - Combinational from inputs; no registered grant delay.
- Push: on data_gnt_o, write {tag, index, wdata, be, size} at wr_ptr. wr_ptr wraps modulo DEPTH.
- Response: data_rvalid_o pulses exactly 1 cycle after each grant.
- Kill: kill_req_i has no effect on an already-granted write. It is ignored in every state.
- Unsupported request: data_req_i=1 with data_we_i=0 is never granted. err_o pulses in that cycle.
- Drain FSM:
  - IDLE: if count_q != 0, go to REQ.
  - REQ: mem_req_o=1 and mem_* driven from the head entry, held stable until mem_gnt_i. On mem_gnt_i go to WAIT_ACK. If mem_ack_i arrives in the same cycle as mem_gnt_i, pop and go to IDLE.
  - WAIT_ACK: mem_req_o=0. On mem_ack_i, pop (rd_ptr wraps modulo DEPTH) and go to IDLE.
  - Throughput is at most one drain per 2 cycles: the cycle after a pop is always IDLE.
- Count update:
  - Push and pop in the same cycle: count unchanged.
  - count never exceeds DEPTH and never underflows.
  - Pop occurs only while count_q != 0, guaranteed by the FSM.
- Ordering: memory writes are issued strictly in grant order. There is no merging and no byte-enable modification.
- mem_* outputs are 0 when mem_req_o=0.
- empty_o = (count_q == 0) & (state == IDLE).

Test Plan:
1. Reset, then a single write (idx 0x010, tag 0x1, wdata 0xDEADBEEF_CAFEF00D, be 0xFF, size 3) with mem_gnt_i and mem_ack_i tied high.
   - gnt in the same cycle; rvalid 1 cycle later.
   - mem_req_o one cycle after the push, with mem_addr_o = 0x1010.
   - empty_o=1 again 2 cycles after the push (the cycle after the pop).
2. Five back-to-back writes with mem_gnt_i held low:
   - First four granted; count_o reaches 4.
   - Fifth sees data_gnt_o=0 until the first pop.
   - The fifth is not granted in the pop cycle itself; it is granted the next cycle.
3. Wrap-around: ten writes with alternating be 0x0F/0xF0 and random memory stall 0-3 cycles.
   - Memory receives all ten in order with identical address, data and be.
4. Read request (data_we_i=0, data_req_i=1):
   - data_gnt_o=0 and err_o=1 for every cycle the request is held.
   - FIFO unchanged.
5. kill_req_i=1 in the cycle after a grant:
   - rvalid still pulses.
   - The entry is still written to memory.
6. Assert rst_ni low while in WAIT_ACK with 3 entries queued:
   - mem_req_o=0, count_o=0, empty_o=1 immediately.
   - No pop or memory request after release.
